// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types and constants.
//   req_entry_t    : one queued data request (write flag, address, store data)
//                    at the default 32-bit address/data widths.
//   IREN_ALWAYS    : iREN held high whenever out of reset.
//   IREN_EXCLUSIVE : iREN low while any data request is queued.
//   wd_width()     : counter width able to hold a watchdog limit.
package cpu_types_pkg;

  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef struct packed {
    logic              wr;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] data;
  } req_entry_t;

  localparam int IREN_ALWAYS    = 0;
  localparam int IREN_EXCLUSIVE = 1;

  // A limit of 0 or 1 still needs a 1-bit counter.
  function automatic int wd_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/request_queue_unit_if.sv
// Memory-controller side of the request queue.
//   dREN/dWEN          : head request is a read / write
//   dmemaddr/dmemstore : head request address / store data
//   iREN               : instruction read enable
//   dhit               : controller completed the head data request
// master = request queue, slave = memory controller.
interface request_queue_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          iREN;
  logic          dhit;

  modport master (output dREN, dWEN, dmemaddr, dmemstore, iREN, input dhit);
  modport slave  (input dREN, dWEN, dmemaddr, dmemstore, iREN, output dhit);
endinterface

// File: rtl/request_fifo.sv
// Circular request buffer with count-based full/empty.
//   push/wdata : append an entry (ignored when full or during flush_tail)
//   pop        : retire the head (ignored when empty)
//   flush_tail : drop every entry behind the head; with pop, drop everything
//   head       : entry at the read pointer
//   full/empty/count : occupancy
module request_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          push,
  input  logic          pop,
  input  logic          flush_tail,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush_tail;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_tail) begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wr_ptr <= rd_ptr + PW'(1);
        count  <= '0;
      end else if (!empty) begin
        // Keep only the head: it may already be in the memory controller.
        wr_ptr <= rd_ptr + PW'(1);
        count  <= CW'(1);
      end
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/request_queue_unit.sv
// Buffers pipeline data requests and issues them one at a time to memory.
//   CLK, nRST          : clock, asynchronous active-low reset
//   ihit               : fetch completed; qualifies memread/memwr
//   memread/memwr      : load / store request (both set = store)
//   daddr/dstore       : request address / store data
//   flush              : drop queued requests that are not yet issued
//   full/empty/count   : queue occupancy, full stalls the pipeline
//   timeout_err        : sticky watchdog error
//   mem                : memory-controller side (dREN/dWEN/dmemaddr/dmemstore/iREN, dhit)
module request_queue_unit
  import cpu_types_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int DEPTH          = 4,
  parameter int IREN_MODE      = IREN_ALWAYS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ihit,
  input  logic                   memread,
  input  logic                   memwr,
  input  logic [AW-1:0]          daddr,
  input  logic [DW-1:0]          dstore,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   timeout_err,
  request_queue_unit_if.master   mem
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int EW   = 1 + AW + DW;
  localparam int WD_W = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES);

  // Same layout as req_entry_t, sized by this instance's widths.
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          wentry;
  entry_t          head;
  entry_t          next_src;
  logic [EW-1:0]   head_vec;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;
  logic            out_vld_next;
  logic [WD_W-1:0] wd;
  logic [WD_W-1:0] wd_next;

  logic            dren_r;
  logic            dwen_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   data_r;
  logic            iren_r;

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v,
                                              input logic [WD_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

  // A store wins when both request flags are set.
  assign wentry = '{wr: memwr, addr: daddr, data: dstore};
  assign push   = ihit & (memread | memwr) & ~q_full & ~flush;
  assign pop    = mem.dhit & ~q_empty;

  request_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .push       (push),
    .pop        (pop),
    .flush_tail (flush),
    .wdata      (wentry),
    .head       (head_vec),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  assign head = entry_t'(head_vec);

  always_comb begin
    count_next = q_count + CW'(push) - CW'(pop);
    if (flush) count_next = (pop || q_empty) ? '0 : CW'(1);
  end

  // A push into an empty queue is issued straight from the input entry so it
  // shows up the cycle after acceptance. After a pop the outputs go idle for
  // one cycle so the retired op is never seen twice.
  assign next_src     = q_empty ? wentry : head;
  assign out_vld_next = ~pop & (count_next != '0);

  always_comb begin
    wd_next = sat_inc(wd, WD_LIM);
    if (q_empty || mem.dhit) wd_next = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dren_r      <= 1'b0;
      dwen_r      <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      iren_r      <= 1'b0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      dren_r <= out_vld_next & ~next_src.wr;
      dwen_r <= out_vld_next & next_src.wr;
      addr_r <= out_vld_next ? next_src.addr : '0;
      data_r <= (out_vld_next && next_src.wr) ? next_src.data : '0;
      iren_r <= (IREN_MODE == IREN_EXCLUSIVE) ? (count_next == '0) : 1'b1;
      wd     <= wd_next;
      if ((TIMEOUT_CYCLES != 0) && (wd_next >= WD_LIM)) timeout_err <= 1'b1;
    end
  end

  assign full          = q_full;
  assign empty         = q_empty;
  assign count         = q_count;
  assign mem.dREN      = dren_r;
  assign mem.dWEN      = dwen_r;
  assign mem.dmemaddr  = addr_r;
  assign mem.dmemstore = data_r;
  assign mem.iREN      = iren_r;

endmodule

// File: tb/tb_request_queue_unit.sv
module tb_request_queue_unit;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        ihit = 1'b0, memread = 1'b0, memwr = 1'b0, flush = 1'b0, dhit = 1'b0;
  logic [31:0] daddr = '0, dstore = '0;
  logic        full0, empty0, err0, full1, empty1, err1;
  logic [2:0]  count0, count1;

  request_queue_unit_if #(.AW(32), .DW(32)) bus0 ();
  request_queue_unit_if #(.AW(32), .DW(32)) bus1 ();
  assign bus0.dhit = dhit;
  assign bus1.dhit = dhit;

  request_queue_unit #(.AW(32), .DW(32), .DEPTH(DEPTH), .IREN_MODE(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .memread(memread), .memwr(memwr), .daddr(daddr),
    .dstore(dstore), .flush(flush), .full(full0), .empty(empty0), .count(count0),
    .timeout_err(err0), .mem(bus0));

  request_queue_unit #(.AW(32), .DW(32), .DEPTH(DEPTH), .IREN_MODE(1), .TIMEOUT_CYCLES(TO)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .memread(memread), .memwr(memwr), .daddr(daddr),
    .dstore(dstore), .flush(flush), .full(full1), .empty(empty1), .count(count1),
    .timeout_err(err1), .mem(bus1));

  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } m_entry_t;

  typedef struct {
    int          count;
    bit          full, empty, dren, dwen, iren0, iren1, err;
    logic [31:0] addr, data;
  } exp_t;

  m_entry_t mq[$];
  exp_t     exp_q[$];
  int       m_wd;
  bit       m_err;
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain queue of requests, advanced once per clock.
  task automatic step();
    exp_t     e;
    m_entry_t ent;
    int       sz;
    bit       req, pop, acc;
    sz  = mq.size();
    req = ihit && (memread || memwr);
    pop = dhit && (sz > 0);
    acc = req && (sz < DEPTH) && !flush;
    if (sz == 0 || dhit) m_wd = 0;
    else if (m_wd < TO) m_wd = m_wd + 1;
    if (m_wd >= TO) m_err = 1;
    if (pop) mq.delete(0);
    if (flush) begin
      if (pop) mq.delete();
      else while (mq.size() > 1) mq.delete(mq.size() - 1);
    end
    if (acc) begin
      ent.wr = memwr; ent.addr = daddr; ent.data = dstore;
      mq.push_back(ent);
    end
    e.count = mq.size();
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    e.dren = 0; e.dwen = 0; e.addr = '0; e.data = '0;
    if (!pop && mq.size() > 0) begin
      e.dren = !mq[0].wr;
      e.dwen = mq[0].wr;
      e.addr = mq[0].addr;
      e.data = mq[0].wr ? mq[0].data : 32'h0;
    end
    e.iren0 = 1;
    e.iren1 = (mq.size() == 0);
    e.err   = m_err;
    @(posedge CLK);
    #1;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (nRST && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", 64'(count0), 64'(e.count));
      chk("full", 64'(full0), 64'(e.full));
      chk("empty", 64'(empty0), 64'(e.empty));
      chk("dREN", 64'(bus0.dREN), 64'(e.dren));
      chk("dWEN", 64'(bus0.dWEN), 64'(e.dwen));
      chk("dmemaddr", 64'(bus0.dmemaddr), 64'(e.addr));
      chk("dmemstore", 64'(bus0.dmemstore), 64'(e.data));
      chk("iREN_mode0", 64'(bus0.iREN), 64'(e.iren0));
      chk("iREN_mode1", 64'(bus1.iREN), 64'(e.iren1));
      chk("timeout_err", 64'(err0), 64'(e.err));
      chk("count_mode1", 64'(count1), 64'(e.count));
      chk("dREN_mode1", 64'(bus1.dREN), 64'(e.dren));
      chk("timeout_err_mode1", 64'(err1), 64'(e.err));
    end
  end

  task automatic drive(input bit ih, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit fl, input bit dh);
    ihit = ih; memread = rd; memwr = wr; daddr = a; dstore = d; flush = fl; dhit = dh;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic check_reset_values();
    chk("rst_dREN", 64'(bus0.dREN), 64'd0);
    chk("rst_dWEN", 64'(bus0.dWEN), 64'd0);
    chk("rst_dmemaddr", 64'(bus0.dmemaddr), 64'd0);
    chk("rst_dmemstore", 64'(bus0.dmemstore), 64'd0);
    chk("rst_count", 64'(count0), 64'd0);
    chk("rst_empty", 64'(empty0), 64'd1);
    chk("rst_full", 64'(full0), 64'd0);
    chk("rst_iREN0", 64'(bus0.iREN), 64'd0);
    chk("rst_iREN1", 64'(bus1.iREN), 64'd0);
    chk("rst_timeout_err", 64'(err0), 64'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_wd  = 0;
    m_err = 0;
  endtask

  initial begin
    #1 nRST = 1'b0;
    #1 check_reset_values();
    model_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    idle(3);

    // Single read, completed two cycles after issue.
    drive(1, 1, 0, 32'h100, 32'hdead, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Five back-to-back stores into a four-deep queue, then drain.
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 32'h10 + i, 32'ha0 + i, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      idle(1);
    end

    // Full queue with push+dhit, then push+dhit at count 2 across the wrap.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 32'h200 + i, 0, 0, 0);
    drive(1, 1, 1, 32'h2ff, 32'h55, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) drive(1, i[0], 1, 32'h300 + i, 32'hb00 + i, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      idle(1);
    end

    // Flush keeps only the head, then flush with push, then flush with dhit.
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 32'h400 + i, 32'hc0 + i, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 32'h500 + i, 0, 0, 0);
    drive(1, 1, 0, 32'h5ff, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // Read left pending long enough to trip the watchdog.
    drive(1, 1, 0, 32'h600, 0, 0, 0);
    idle(TO + 2);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Asynchronous reset in the middle of traffic.
    drive(1, 0, 1, 32'h700, 32'h77, 0, 0);
    drive(1, 1, 0, 32'h704, 0, 0, 0);
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1 check_reset_values();
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 35);
    end
    for (int i = 0; i < DEPTH + 1; i++) drive(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/request_queue_unit.md
Name: request_queue_unit

Overview:
Parametrised successor to the single-shot request unit. It sits between the pipeline and the memory controller. Data requests (read/write) qualified by ihit are buffered in a small FIFO and issued one at a time, each held until dhit. iREN behaviour is mode-selectable, and a watchdog flags a data request that never completes. Back-pressure to the pipeline is via full.

Parameters:
AW, 32, address width
DW, 32, store-data width
DEPTH, 4, queue entries (power of 2, >=2)
IREN_MODE, 0, 0 = iREN always high after reset; 1 = iREN low while any data op is queued
TIMEOUT_CYCLES, 1024, cycles a head request may wait for dhit before timeout_err; 0 disables the watchdog

Ports:
CLK  in  1  clock
nRST  in  1  reset
ihit  in  1  instruction fetch completed this cycle; qualifies memread/memwr
memread  in  1  current instruction is a load
memwr  in  1  current instruction is a store
daddr  in  AW  data address of the current instruction
dstore  in  DW  store data of the current instruction
flush  in  1  drop queued, not-yet-issued requests
dhit  in  1  memory controller completed the head data request
dREN  out  1  head request is a read
dWEN  out  1  head request is a write
dmemaddr  out  AW  head request address
dmemstore  out  DW  head request store data (0 for reads)
iREN  out  1  instruction read enable
full  out  1  queue full; pipeline must stall
empty  out  1  no queued data requests
count  out  $clog2(DEPTH)+1  queued entries
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset nRST, asynchronous, active-low; clock CLK. All state is updated on posedge CLK.
- Reset values: queue empty, count=0, empty=1, full=0, dREN=dWEN=0, dmemaddr=0, dmemstore=0, iREN=0, timeout_err=0, watchdog=0.
- First edge after reset: iREN<=1 (mode 0), or iREN<=empty_next (mode 1).
- Enqueue condition: ihit & (memread|memwr) & !full. full is the registered count==DEPTH; a pop in the same cycle does not unblock the push.
- memread & memwr both set: the entry is a write; the read is discarded.
- Dropped push: a request presented while full is not enqueued. The pipeline must re-present it after full falls.
- Outputs from head: dREN, dWEN, dmemaddr and dmemstore are driven only from head-entry flops, with no combinational path from the inputs.
- Latency: a request accepted at edge t into an empty queue is visible on dREN/dWEN in the cycle after edge t.
- Pop: dhit with a valid head pops it at the edge. The next entry appears in the following cycle. dREN/dWEN fall for at least that cycle boundary, so the same op is never re-issued.
- dhit while empty: ignored.
- Simultaneous push and pop: both occur and count is unchanged. Push into an empty queue with a simultaneous dhit: the dhit is ignored.
- count arithmetic: saturates at DEPTH; never underflows.
- Pointer wrap: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, not pointer compare.
- flush: discards every entry except the head, because the head may already be in the memory controller.
  - flush with dhit in the same cycle: the queue becomes empty.
  - flush with a push in the same cycle: the push is dropped.
- Watchdog counter:
  - Increments each cycle the head is valid and dhit=0.
  - Clears on dhit or when the queue is empty.
  - When it reaches TIMEOUT_CYCLES (non-zero), timeout_err<=1 and stays set until reset.
  - Queue behaviour is unchanged by timeout_err.
  - The counter saturates; it is wide enough for TIMEOUT_CYCLES.
- Mode 1 iREN: iREN<=(count_next==0). Instruction fetch resumes the cycle after the last dhit.

Decomposition:
- Shared package cpu_types_pkg gains:
  - typedef req_entry_t, a packed struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data}.
  - localparams IREN_ALWAYS=0 and IREN_EXCLUSIVE=1.
- Sub-module request_fifo holds storage, pointers and count, parametrised on DEPTH and entry width. It provides push/pop/flush_tail ports and head/full/empty/count outputs.
- The top level contains the enqueue qualification, the iREN register, the watchdog and the output decode.

Test Plan:
- Reset, then idle 3 cycles -> dREN=dWEN=0, empty=1, count=0; iREN 0 during reset, 1 from the first edge (mode 0).
- ihit+memread, daddr=0x100 -> next cycle dREN=1, dmemaddr=0x100. dhit two cycles later -> dREN=0 the next cycle, empty=1.
- DEPTH=4: 5 back-to-back ihit stores 0x10..0x14, no dhit -> full=1 after the 4th; the 5th is dropped. Four dhits -> addresses 0x10..0x13 issued in order, dmemstore matching.
- Full queue with simultaneous push+dhit -> push dropped, count goes 4->3. Count=2 with push+dhit -> count stays 2, FIFO order preserved across pointer wrap (>=10 ops).
- 3 queued, flush=1 -> count=1, head unchanged. dhit -> empty=1. Mode 1: iREN=0 while queued, 1 the cycle after the final dhit.
- TIMEOUT_CYCLES=8, read queued with no dhit -> timeout_err=1 after 8 cycles. Later dhit -> timeout_err stays 1; nRST pulse mid-operation -> everything returns to reset values.
